// File: rtl/list_ctrl_lru.sv
// Per-set LRU recency lists with two access ports and a one-cycle registered response.
// Same-set requests in one cycle are chained: port 1 operates on the list as port 0 leaves it.
module list_ctrl_lru #(
  parameter int list_depth  = 4,
  parameter int index_lenth = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          acc_req_0,
  input  logic [index_lenth-1:0]        acc_index_0,
  input  logic [1:0]                    acc_cmd_0,
  input  logic [$clog2(list_depth)-1:0] acc_tag_0,
  output logic [$clog2(list_depth)-1:0] return_tag_0,
  output logic [2:0]                    acc_status_0,
  input  logic                          acc_req_1,
  input  logic [index_lenth-1:0]        acc_index_1,
  input  logic [1:0]                    acc_cmd_1,
  input  logic [$clog2(list_depth)-1:0] acc_tag_1,
  output logic [$clog2(list_depth)-1:0] return_tag_1,
  output logic [2:0]                    acc_status_1
);
  localparam int TW   = $clog2(list_depth);
  localparam int NSET = 1 << index_lenth;

  localparam logic [1:0] CMD_GET    = 2'b00;
  localparam logic [1:0] CMD_TOUCH  = 2'b01;
  localparam logic [1:0] CMD_ALLOC  = 2'b10;
  localparam logic [1:0] CMD_DEMOTE = 2'b11;

  typedef logic [list_depth-1:0][TW-1:0] list_t;  // [0] = MRU
  typedef struct packed {
    list_t          lst;
    logic [TW-1:0]  tag;
    logic           noop;
  } res_t;

  list_t         lists_q [NSET];
  logic [TW-1:0] ret0_q, ret1_q;
  logic [2:0]    st0_q, st1_q;

  res_t  res0_d, res1_d;
  list_t base1;
  logic  coll;

  function automatic res_t apply(input list_t li, input logic [1:0] cmd, input logic [TW-1:0] tag);
    res_t r;
    int   p;
    logic [TW-1:0] t;
    t      = (cmd == CMD_GET || cmd == CMD_ALLOC) ? li[list_depth-1] : tag;
    r.lst  = li;
    r.tag  = t;
    r.noop = 1'b0;
    p      = 0;
    for (int i = 0; i < list_depth; i++)
      if (li[i] == t) p = i;
    case (cmd)
      CMD_TOUCH, CMD_ALLOC: begin
        r.lst[0] = t;
        for (int i = 1; i < list_depth; i++)
          if (i <= p) r.lst[i] = li[i-1];
        r.noop = (cmd == CMD_TOUCH) && (p == 0);
      end
      CMD_DEMOTE: begin
        for (int i = 0; i < list_depth - 1; i++)
          if (i >= p) r.lst[i] = li[i+1];
        r.lst[list_depth-1] = t;
        r.noop = (p == list_depth - 1);
      end
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    coll   = acc_req_0 && acc_req_1 && (acc_index_0 == acc_index_1);
    res0_d = apply(lists_q[acc_index_0], acc_cmd_0, acc_tag_0);
    base1  = (acc_req_0 && acc_index_0 == acc_index_1) ? res0_d.lst : lists_q[acc_index_1];
    res1_d = apply(base1, acc_cmd_1, acc_tag_1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSET; s++)
        for (int i = 0; i < list_depth; i++)
          lists_q[s][i] <= TW'(i);
      ret0_q <= '0;
      ret1_q <= '0;
      st0_q  <= '0;
      st1_q  <= '0;
    end else begin
      // Port 1 writes last so a same-set pair commits the chained result.
      if (acc_req_0) lists_q[acc_index_0] <= res0_d.lst;
      if (acc_req_1) lists_q[acc_index_1] <= res1_d.lst;
      if (acc_req_0) ret0_q <= res0_d.tag;
      if (acc_req_1) ret1_q <= res1_d.tag;
      st0_q <= acc_req_0 ? {res0_d.noop, coll, 1'b1} : 3'b000;
      st1_q <= acc_req_1 ? {res1_d.noop, coll, 1'b1} : 3'b000;
    end
  end

  assign return_tag_0 = ret0_q;
  assign return_tag_1 = ret1_q;
  assign acc_status_0 = st0_q;
  assign acc_status_1 = st1_q;
endmodule

// File: tb/tb_list_ctrl_lru.sv
// Scoreboard bench for list_ctrl_lru: a queue-based recency model predicts each port's response.
module tb_list_ctrl_lru;
  localparam int D  = 4;
  localparam int IW = 4;
  localparam int TW = 2;
  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [IW-1:0] idx0, idx1;
  logic [1:0]    cmd0, cmd1;
  logic [TW-1:0] tag0, tag1;
  logic [TW-1:0] rtag0, rtag1;
  logic [2:0]    st0, st1;

  list_ctrl_lru #(.list_depth(D), .index_lenth(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_req_0(req0), .acc_index_0(idx0), .acc_cmd_0(cmd0), .acc_tag_0(tag0),
    .return_tag_0(rtag0), .acc_status_0(st0),
    .acc_req_1(req1), .acc_index_1(idx1), .acc_cmd_1(cmd1), .acc_tag_1(tag1),
    .return_tag_1(rtag1), .acc_status_1(st1)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; int st; } exp_t;
  exp_t q0[$], q1[$];
  int   model [NS][D];
  int   hold0, hold1;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < D; i++) model[s][i] = i;
    hold0 = 0;
    hold1 = 0;
  endtask

  // Recency list as a queue: front = MRU, back = LRU.
  task automatic model_op(input int idx, input int cmd, input int tag, output int rt, output int noop);
    int lst[$];
    int p;
    lst = {};
    for (int i = 0; i < D; i++) lst.push_back(model[idx][i]);
    if (cmd == 0 || cmd == 2) tag = lst[D-1];
    p = 0;
    for (int i = 0; i < D; i++) if (lst[i] == tag) p = i;
    rt = tag;
    noop = 0;
    case (cmd)
      1: begin noop = (p == 0);     lst.delete(p); lst.push_front(tag); end
      2: begin                      lst.delete(p); lst.push_front(tag); end
      3: begin noop = (p == D - 1); lst.delete(p); lst.push_back(tag);  end
      default: ;
    endcase
    for (int i = 0; i < D; i++) model[idx][i] = lst[i];
  endtask

  task automatic cycle(input bit r0, input int i0, input int c0, input int t0,
                       input bit r1, input int i1, input int c1, input int t1);
    int   rt, noop, coll;
    exp_t e;
    @(negedge clk);
    req0 = r0; idx0 = IW'(i0); cmd0 = 2'(c0); tag0 = TW'(t0);
    req1 = r1; idx1 = IW'(i1); cmd1 = 2'(c1); tag1 = TW'(t1);
    coll = (r0 && r1 && i0 == i1) ? 1 : 0;
    e.st = 0;
    if (r0) begin model_op(i0, c0, t0, rt, noop); hold0 = rt; e.st = 1 + 2*coll + 4*noop; end
    e.tag = hold0;
    q0.push_back(e);
    e.st = 0;
    if (r1) begin model_op(i1, c1, t1, rt, noop); hold1 = rt; e.st = 1 + 2*coll + 4*noop; end
    e.tag = hold1;
    q1.push_back(e);
    @(posedge clk);
    #1;
    e = q0.pop_front();
    chk("p0_tag", int'(rtag0), e.tag);
    chk("p0_status", int'(st0), e.st);
    e = q1.pop_front();
    chk("p1_tag", int'(rtag1), e.tag);
    chk("p1_status", int'(st1), e.st);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; idx0 = '0; cmd0 = '0; tag0 = '0;
    req1 = 0; idx1 = '0; cmd1 = '0; tag1 = '0;
    model_reset();
    #12;
    chk("rst_tag0", int'(rtag0), 0);
    chk("rst_st0", int'(st0), 0);
    chk("rst_tag1", int'(rtag1), 0);
    chk("rst_st1", int'(st1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1, 5, 0, 0, 0, 0, 0, 0);                        // GET_LRU -> 3
    cycle(1, 5, 0, 0, 0, 0, 0, 0);                        // unchanged
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 1, 2, 2, 0);  // 3,2,1,0,3
    cycle(1, 0, 1, 3, 0, 0, 0, 0);                        // TOUCH 3
    cycle(1, 0, 0, 0, 0, 0, 0, 0);                        // LRU 2
    cycle(1, 0, 1, 3, 0, 0, 0, 0);                        // no-op
    cycle(1, 7, 3, 0, 0, 0, 0, 0);                        // DEMOTE 0
    cycle(1, 7, 0, 0, 0, 0, 0, 0);                        // LRU 0
    cycle(1, 7, 3, 0, 0, 0, 0, 0);                        // no-op
    cycle(1, 1, 2, 0, 1, 1, 2, 0);                        // collision: 3 / 2
    cycle(1, 1, 0, 0, 0, 0, 0, 0);                        // LRU 1
    cycle(1, 6, 2, 0, 1, 4, 2, 0);                        // independent: 3 / 3
    cycle(1, 9, 1, 2, 1, 9, 3, 2);                        // chained TOUCH then DEMOTE

    // Reset landing on a request edge: no ack, lists reinitialized.
    @(negedge clk);
    req0 = 1; idx0 = 4'd3; cmd0 = 2'b10; req1 = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_st0", int'(st0), 0);
    chk("midrst_tag0", int'(rtag0), 0);
    @(negedge clk);
    req0 = 0;
    rst_n = 1'b1;
    model_reset();
    cycle(1, 3, 0, 0, 0, 0, 0, 0);                        // LRU 3 again
    cycle(1, 9, 0, 0, 0, 0, 0, 0);                        // set 9 back to reset order

    for (int k = 0; k < 400; k++)
      cycle($urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(D-1, 0),
            $urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(D-1, 0));

    // Drain each hot set through ALLOCs: every tag must come out once in model order.
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < D; k++) cycle(1, s, 2, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
